multi_priority_encoder_disp: RTL and testbench



---
 rtl/multi_priority_encoder_disp_pkg.sv | 37 +++
 rtl/multi_priority_encoder_disp_seg_scan.sv | 61 ++++++
 rtl/multi_priority_encoder_disp.sv | 136 +++++++++++++
 tb/tb_multi_priority_encoder_disp.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multi_priority_encoder_disp_pkg.sv
// Shared constants and helpers for the multi-winner priority encoder display.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package multi_priority_encoder_disp_pkg;

    localparam logic [7:0] SSEG_BLANK = 8'hFF;
    localparam logic [7:0] SSEG_DASH  = 8'hBF;

    // Width of a digit index; a single digit still needs one bit.
    function automatic int dig_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Hex glyph without dp, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex2seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multi_priority_encoder_disp_seg_scan.sv
// Digit scan timer: slot counter, digit index and active-low enable decode.
// o_digit is the digit the registers move to on this edge, so sseg can track en.
module seg_scan
    import multi_priority_encoder_disp_pkg::*;
#(
    parameter int K_WIN       = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16,
    parameter int DIG_W       = dig_w(K_WIN)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [DIG_W-1:0] o_digit,
    output logic [K_WIN-1:0] o_en
);

    logic [CNT_W-1:0] r_cnt;
    logic [DIG_W-1:0] r_digit;
    logic [K_WIN-1:0] r_en;
    logic             w_tick;
    logic [DIG_W-1:0] w_digit_nxt;
    logic [K_WIN-1:0] w_en_nxt;

    assign w_tick = (r_cnt == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        w_digit_nxt = r_digit;
        if (w_tick) begin
            if (r_digit == DIG_W'(K_WIN - 1))
                w_digit_nxt = '0;
            else
                w_digit_nxt = r_digit + 1'b1;
        end
    end

    // Digit d lights en[K_WIN-1-d] so winner 0 sits on the leftmost digit.
    always_comb begin
        w_en_nxt = '1;
        for (int d = 0; d < K_WIN; d++) begin
            if (int'(w_digit_nxt) == K_WIN - 1 - d)
                w_en_nxt[d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt            <= '0;
            r_digit          <= '0;
            r_en             <= '1;
            r_en[K_WIN-1]    <= 1'b0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            r_digit <= w_digit_nxt;
            r_en    <= w_en_nxt;
        end
    end

    assign o_digit = w_digit_nxt;
    assign o_en    = r_en;

endmodule

// File: rtl/multi_priority_encoder_disp.sv
// K-winner priority encoder with a time-multiplexed seven-segment display.
// Optional DP_CHANGE_EN: dp marks a winner that changed, for one scan slot.
module multi_priority_encoder_disp
    import multi_priority_encoder_disp_pkg::*;
#(
    parameter int N_REQ       = 12,
    parameter int K_WIN       = 3,
    parameter int IDX_W       = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic                   hold,
    output logic [K_WIN*IDX_W-1:0] win_idx,
    output logic [K_WIN-1:0]       win_vld,
    output logic [7:0]             sseg,
    output logic [K_WIN-1:0]       en
);

    localparam int DIG_W = dig_w(K_WIN);

    logic [N_REQ-1:0]              r_req;
    logic [K_WIN*IDX_W-1:0]        r_win_idx;
    logic [K_WIN-1:0]              r_win_vld;
    logic [K_WIN*IDX_W-1:0]        w_win_idx;
    logic [K_WIN-1:0]              w_win_vld;
    logic [K_WIN-1:0][N_REQ-1:0]   w_rem;
    logic [DIG_W-1:0]              w_digit;
    logic [IDX_W-1:0]              w_sel_idx;
    logic [6:0]                    w_glyph;
    logic                          w_dp;
    logic [7:0]                    r_sseg;

    assign w_rem[0] = r_req;

    // Each stage takes the top remaining bit and masks it for the next.
    for (genvar k = 0; k < K_WIN; k++) begin : g_win
        logic [IDX_W-1:0] w_idx;
        logic             w_vld;
        logic [N_REQ-1:0] w_hit;

        always_comb begin
            w_idx = '0;
            w_vld = 1'b0;
            w_hit = '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (w_rem[k][i]) begin
                    w_idx    = IDX_W'(i);
                    w_vld    = 1'b1;
                    w_hit    = '0;
                    w_hit[i] = 1'b1;
                end
            end
        end

        if (k < K_WIN - 1) begin : g_nxt
            assign w_rem[k+1] = w_rem[k] & ~w_hit;
        end

        assign w_win_idx[k*IDX_W +: IDX_W] = w_idx;
        assign w_win_vld[k]                = w_vld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req     <= '0;
            r_win_idx <= '0;
            r_win_vld <= '0;
        end else begin
            r_req <= req;
            if (!hold) begin
                r_win_idx <= w_win_idx;
                r_win_vld <= w_win_vld;
            end
        end
    end

    seg_scan #(
        .K_WIN       (K_WIN),
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W),
        .DIG_W       (DIG_W)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .o_digit (w_digit),
        .o_en    (en)
    );

`ifdef DP_CHANGE_EN
    logic [K_WIN-1:0] r_chg;
    logic [K_WIN-1:0] w_chg_nxt;

    // A slot ends when its digit is lit now but the scan is moving on.
    always_comb begin
        w_chg_nxt = r_chg;
        for (int k = 0; k < K_WIN; k++) begin
            if (!en[K_WIN-1-k] && int'(w_digit) != k)
                w_chg_nxt[k] = 1'b0;
            if (!hold &&
                ((w_win_idx[k*IDX_W +: IDX_W] != r_win_idx[k*IDX_W +: IDX_W]) ||
                 (w_win_vld[k] != r_win_vld[k])))
                w_chg_nxt[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_chg <= '0;
        else
            r_chg <= w_chg_nxt;
    end

    assign w_dp = ~r_chg[w_digit];
`else
    assign w_dp = 1'b1;
`endif

    assign w_sel_idx = r_win_idx[w_digit*IDX_W +: IDX_W];
    assign w_glyph   = r_win_vld[w_digit] ? hex2seg7(4'(w_sel_idx))
                                          : SSEG_DASH[6:0];

    always_ff @(posedge clk) begin
        if (rst)
            r_sseg <= SSEG_BLANK;
        else
            r_sseg <= {w_dp, w_glyph};
    end

    assign win_idx = r_win_idx;
    assign win_vld = r_win_vld;
    assign sseg    = r_sseg;

endmodule

// File: tb/tb_multi_priority_encoder_disp.sv
// Scoreboard bench: a behavioural model queues expected outputs per edge,
// a monitor pops and compares them one time unit after each rising edge.
module tb_multi_priority_encoder_disp;

    localparam int N  = 12;
    localparam int K  = 3;
    localparam int IW = 4;
    localparam int RD = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic [N-1:0]      req;
    logic [K*IW-1:0]   win_idx;
    logic [K-1:0]      win_vld;
    logic [7:0]        sseg;
    logic [K-1:0]      en;

    always #5 clk = ~clk;

    multi_priority_encoder_disp #(
        .N_REQ       (N),
        .K_WIN       (K),
        .IDX_W       (IW),
        .REFRESH_DIV (RD),
        .CNT_W       (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .hold    (hold),
        .win_idx (win_idx),
        .win_vld (win_vld),
        .sseg    (sseg),
        .en      (en)
    );

    typedef struct {
        logic [K*IW-1:0] idx;
        logic [K-1:0]    vld;
        logic [K-1:0]    en;
        logic [7:0]      sseg;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    logic [7:0] GLYPH [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic [N-1:0]    m_req = '0;
    logic [K*IW-1:0] m_idx = '0;
    logic [K-1:0]    m_vld = '0;
    int              m_n   = 0;

    // Winners listed from the highest set bit downward, first K taken.
    task automatic winners(input logic [N-1:0] r,
                           output logic [K*IW-1:0] wi,
                           output logic [K-1:0] wv);
        int c;
        c  = 0;
        wi = '0;
        wv = '0;
        for (int b = N - 1; b >= 0; b--) begin
            if (r[b] && c < K) begin
                wi[c*IW +: IW] = IW'(b);
                wv[c]          = 1'b1;
                c++;
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic h, input logic rs);
        exp_t            e;
        logic [K*IW-1:0] p_idx;
        logic [K-1:0]    p_vld;
        logic [K*IW-1:0] wi;
        logic [K-1:0]    wv;
        int              d;
        req   = r;
        hold  = h;
        rst   = rs;
        p_idx = m_idx;
        p_vld = m_vld;
        if (rs) begin
            m_req  = '0;
            m_idx  = '0;
            m_vld  = '0;
            m_n    = 0;
            e.sseg = 8'hFF;
        end else begin
            if (!h) begin
                winners(m_req, wi, wv);
                m_idx = wi;
                m_vld = wv;
            end
            m_req = r;
            m_n++;
            d = (m_n / RD) % K;
            e.sseg = p_vld[d] ? GLYPH[p_idx[d*IW +: IW]] : 8'hBF;
        end
        d        = (m_n / RD) % K;
        e.en     = '1;
        e.en[K-1-d] = 1'b0;
        e.idx    = m_idx;
        e.vld    = m_vld;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = q.pop_front();
                chk("win_idx", 32'(win_idx), 32'(e.idx));
                chk("win_vld", 32'(win_vld), 32'(e.vld));
                chk("en", 32'(en), 32'(e.en));
`ifdef DP_CHANGE_EN
                chk("sseg", 32'(sseg & 8'h7F), 32'(e.sseg & 8'h7F));
`else
                chk("sseg", 32'(sseg), 32'(e.sseg));
`endif
            end
        end
    end

    initial begin : stim
        logic [N-1:0] r;
        logic         h;
        logic         rs;
        req  = '0;
        hold = 1'b0;
        rst  = 1'b1;
        drive('0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        for (int i = 0; i < 3 * RD; i++) drive('0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive(12'h8A4, 1'b0, 1'b0);
        for (int i = 0; i < 3 * RD + 2; i++) drive(12'h001, 1'b0, 1'b0);
        drive(12'h001, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(12'hFFF, 1'b1, 1'b0);
        for (int i = 0; i < 3 * RD; i++) drive(12'hFFF, 1'b0, 1'b0);
        drive(12'h0C3, 1'b0, 1'b0);
        drive(12'h0C3, 1'b0, 1'b0);
        drive(12'h0C3, 1'b1, 1'b1);
        for (int i = 0; i < 2 * RD; i++) drive(12'h0C3, 1'b0, 1'b0);
        drive(12'h0A0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * RD; i++) drive(12'h060, 1'b0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0: r = N'($urandom);
                1: r = N'($urandom & $urandom & $urandom);
                2: r = N'(1) << $urandom_range(0, N - 1);
                default: r = '0;
            endcase
            h  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 80) == 0);
            drive(r, h, rs);
        end
        done = 1'b1;
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
